// File: rtl/sramc_ahb_arbiter_pkg.sv
// Shared definitions for the two-requester AHB-lite arbiter.
// This file holds the AHB encodings, the FSM states and the round-robin pick helper.
package sramc_ahb_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Pick a winner from two requests.
  // A lone requester always wins. On a tie, the requester that was not granted last wins.
  // With no request the result is 0, and the caller ignores it.
  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    logic id;
    id = 1'b0;
    case (r)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      2'b11:   id = ~last;
      default: id = 1'b0;
    endcase
    return id;
  endfunction

  // Convert a requester id into its one-hot completion pulse.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sramc_ahb_arbiter_if.sv
// AHB-lite bus between the arbiter (master) and the sramc_top slave port.
interface sramc_ahb_arbiter_if #(
  parameter int AW = 8
) ();

  logic          hsel;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [AW-1:0] haddr;
  logic [31:0]   hwdata;
  logic          hready_resp;
  logic          hresp;
  logic [31:0]   hrdata;

  modport master (
    output hsel, hwrite, htrans, hsize, haddr, hwdata,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  hsel, hwrite, htrans, hsize, haddr, hwdata,
    output hready_resp, hresp, hrdata
  );

endinterface

// File: rtl/sramc_ahb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// The grant is combinational from the current requests.
// The last-grant pointer updates only when the owner accepts a grant.
module rr_arb2
  import sramc_ahb_arbiter_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] req,
  input  logic       load,
  output logic       grant_id
);

  logic last_grant;

  // Winner for the current request pattern, biased away from the last grant.
  always_comb begin
    grant_id = rr_pick(req, last_grant);
  end

  // Remember who was served last. Reset to 1 so that requester 0 wins the first tie.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      last_grant <= 1'b1;
    end else if (load) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/sramc_ahb_arbiter.sv
// Two-requester AHB-lite master in front of sramc_top.
// Requests are serialised one at a time through IDLE -> ADDR -> DATA -> DONE.
// Every output is registered.
module sramc_ahb_arbiter
  import sramc_ahb_arbiter_pkg::*;
#(
  parameter int AW          = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [31:0]          wdata0,
  input  logic [31:0]          wdata1,
  output logic [1:0]           ack,
  output logic                 err,
  output logic [31:0]          rdata,
  sramc_ahb_arbiter_if.master  ahb
);

  localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

  state_t        state;
  logic          cur_id;
  logic          cur_we;
  logic [31:0]   cur_wdata;
  logic [7:0]    wait_cnt;
  logic          err_pend;

  logic          hsel_q;
  logic          hwrite_q;
  logic [1:0]    htrans_q;
  logic [AW-1:0] haddr_q;
  logic [31:0]   hwdata_q;

  logic          grant_id;
  logic          arb_load;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  // A grant is accepted only from IDLE, when someone is asking and the slave is ready.
  always_comb begin
    arb_load = (state == ST_IDLE) && (req != 2'b00) && ahb.hready_resp;
  end

  rr_arb2 u_arb (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .req      (req),
    .load     (arb_load),
    .grant_id (grant_id)
  );

  // Route the winning requester's operands toward the transfer latches.
  always_comb begin
    sel_we    = we[grant_id];
    sel_addr  = grant_id ? addr1 : addr0;
    sel_wdata = grant_id ? wdata1 : wdata0;
  end

  // Transfer sequencer: one transfer in flight at a time.
  // The DONE edge raises ack, so ack and err appear together in the following IDLE cycle.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      cur_id    <= 1'b0;
      cur_we    <= 1'b0;
      cur_wdata <= 32'h0;
      wait_cnt  <= 8'h0;
      err_pend  <= 1'b0;
      hsel_q    <= 1'b0;
      hwrite_q  <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwdata_q  <= 32'h0;
      ack       <= 2'b00;
      err       <= 1'b0;
      rdata     <= 32'h0;
    end else begin
      ack <= 2'b00;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_load) begin
            cur_id    <= grant_id;
            cur_we    <= sel_we;
            cur_wdata <= sel_wdata;
            err_pend  <= 1'b0;
            hsel_q    <= 1'b1;
            htrans_q  <= HTRANS_NONSEQ;
            hwrite_q  <= sel_we;
            haddr_q   <= sel_addr & ALIGN_MASK;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ahb.hready_resp) begin
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= cur_we ? cur_wdata : 32'h0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (ahb.hready_resp) begin
            if (!cur_we) begin
              rdata <= ahb.hrdata;
            end
            err_pend <= ahb.hresp;
            state    <= ST_DONE;
          end else begin
            // The wait edge that uses up the budget also ends the phase, flagged as an error.
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              err_pend <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          ack      <= id_onehot(cur_id);
          err      <= err_pend;
          hwdata_q <= 32'h0;
          wait_cnt <= 8'h0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ahb.hsel   = hsel_q;
  assign ahb.hwrite = hwrite_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hsize  = HSIZE_WORD;
  assign ahb.haddr  = haddr_q;
  assign ahb.hwdata = hwdata_q;

endmodule

// File: tb/tb_sramc_ahb_arbiter.sv
// Directed bench for sramc_ahb_arbiter, with a small word-memory slave model on the AHB side.
module tb_sramc_ahb_arbiter;

  logic        hclk;
  logic        hresetn;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [7:0]  addr0;
  logic [7:0]  addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  sramc_ahb_arbiter_if #(.AW(8)) bus ();

  sramc_ahb_arbiter #(.AW(8), .TIMEOUT_CYC(16)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .req     (req),
    .we      (we),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ack     (ack),
    .err     (err),
    .rdata   (rdata),
    .ahb     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave model: capture the address phase, then write or read memory in the data phase.
  logic [31:0] mem [0:63];
  logic        ph_valid;
  logic        ph_write;
  logic [7:0]  ph_addr;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    ph_valid = 1'b0;
    ph_write = 1'b0;
    ph_addr  = 8'h0;
  end

  always @(posedge hclk) begin
    if (bus.hready_resp) begin
      if (ph_valid && ph_write) mem[ph_addr[7:2]] <= bus.hwdata;
      ph_valid <= bus.hsel && (bus.htrans == 2'b10);
      ph_write <= bus.hwrite;
      ph_addr  <= bus.haddr;
    end
  end

  assign bus.hrdata = ph_valid ? mem[ph_addr[7:2]] : 32'h0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] assertion tripped: %s", tag);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge hclk);
      #1;
    end
  endtask

  // Step edges until ack shows, up to 64. n counts the edges stepped, including the one that raised ack.
  task automatic waitAck(output int n, output logic [1:0] a, output logic e,
                         output logic [31:0] rd, output logic [7:0] ha);
    n = 0;
    ha = 8'h0;
    while (n < 64) begin
      @(posedge hclk);
      #1;
      n++;
      if (bus.hsel) ha = bus.haddr;
      if (ack != 2'b00) break;
    end
    a = ack;
    e = err;
    rd = rdata;
  endtask

  // Protocol monitor: never both acks at once, and no err without ack.
  always @(negedge hclk) begin
    if (mon_en && hresetn) begin
      checkOutput("ack_onehot", {63'h0, ack == 2'b11}, 64'h0);
      checkOutput("err_wo_ack", {63'h0, (ack == 2'b00) && err}, 64'h0);
    end
  end

  int          n;
  logic [1:0]  a;
  logic        e;
  logic [31:0] rd;
  logic [7:0]  ha;

  initial begin
    hresetn = 1'b0;
    bus.hready_resp = 1'b1;
    bus.hresp = 1'b0;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    cyc(2);
    checkOutput("rst_hsel", bus.hsel, 1'b0);
    checkOutput("rst_htrans", bus.htrans, 2'b00);
    checkOutput("rst_haddr", bus.haddr, 8'h00);
    checkOutput("rst_hwdata", bus.hwdata, 32'h0);
    checkOutput("rst_ack_err", {ack, err}, 3'b000);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("hsize", bus.hsize, 3'b010);
    hresetn = 1'b1;
    mon_en = 1'b1;
    cyc(1);

    // r0 write 0x04, then read it back, both with zero wait states.
    applyStimulus(2'b01, 2'b01, 8'h04, 8'h00, 32'hABCD1234, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("wr_lat", n - 1, 3);
    checkOutput("wr_ack", {a, e}, {2'b01, 1'b0});
    checkOutput("wr_haddr", ha, 8'h04);
    checkOutput("wr_rdata_untouched", rd, 32'h0);
    applyStimulus(2'b01, 2'b00, 8'h04, 8'h00, 32'h0, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("rd_lat", n - 1, 3);
    checkOutput("rd_ack", {a, e}, {2'b01, 1'b0});
    checkOutput("rd_data", rd, 32'hABCD1234);
    checkOutput("hsize_after", bus.hsize, 3'b010);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Reset, then a tie: r0 goes first, then r1.
    hresetn = 1'b0;
    cyc(1);
    hresetn = 1'b1;
    applyStimulus(2'b11, 2'b11, 8'h00, 8'h08, 32'h11111111, 32'h22222222);
    waitAck(n, a, e, rd, ha);
    checkOutput("tie_first", a, 2'b01);
    checkOutput("tie_first_lat", n - 1, 3);
    applyStimulus(2'b10, 2'b11, 8'h00, 8'h08, 32'h11111111, 32'h22222222);
    waitAck(n, a, e, rd, ha);
    checkOutput("tie_second", a, 2'b10);
    checkOutput("tie_second_haddr", ha, 8'h08);
    applyStimulus(2'b01, 2'b00, 8'h00, 8'h08, 32'h0, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("rb_r0", {a, rd}, {2'b01, 32'h11111111});
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h08, 32'h0, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("rb_r1", {a, rd}, {2'b10, 32'h22222222});

    // Held 2'b11 alternates r0, r1, r0.
    applyStimulus(2'b11, 2'b00, 8'h00, 8'h08, 32'h0, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("alt_0", {a, rd}, {2'b01, 32'h11111111});
    waitAck(n, a, e, rd, ha);
    checkOutput("alt_1", {a, rd}, {2'b10, 32'h22222222});
    checkOutput("alt_1_lat", n - 1, 3);
    waitAck(n, a, e, rd, ha);
    checkOutput("alt_2", a, 2'b01);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Unaligned address: bits [1:0] are dropped on the bus.
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h07, 32'h0, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("align_haddr", ha, 8'h04);
    checkOutput("align_rdata", {a, rd}, {2'b10, 32'hABCD1234});
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Slave stalls the address phase for 2 cycles: the address phase must hold.
    applyStimulus(2'b10, 2'b10, 8'h00, 8'h10, 32'h0, 32'h5A5A5A5A);
    cyc(1);
    bus.hready_resp = 1'b0;
    cyc(2);
    checkOutput("addr_hold", {bus.hsel, bus.htrans, bus.hwrite, bus.haddr}, {1'b1, 2'b10, 1'b1, 8'h10});
    bus.hready_resp = 1'b1;
    waitAck(n, a, e, rd, ha);
    checkOutput("addr_wait_lat", 3 + n - 1, 5);
    checkOutput("addr_wait_ack", {a, e}, {2'b10, 1'b0});
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Three data-phase wait states.
    applyStimulus(2'b01, 2'b00, 8'h04, 8'h00, 32'h0, 32'h0);
    cyc(2);
    bus.hready_resp = 1'b0;
    cyc(3);
    checkOutput("data_wait_bus", {bus.hsel, bus.htrans, bus.haddr}, {1'b0, 2'b00, 8'h00});
    bus.hready_resp = 1'b1;
    waitAck(n, a, e, rd, ha);
    checkOutput("data_wait_lat", 5 + n - 1, 6);
    checkOutput("data_wait_rd", {a, e, rd}, {2'b01, 1'b0, 32'hABCD1234});
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Error response at the data-phase completion.
    applyStimulus(2'b01, 2'b00, 8'h04, 8'h00, 32'h0, 32'h0);
    cyc(2);
    bus.hresp = 1'b1;
    waitAck(n, a, e, rd, ha);
    bus.hresp = 1'b0;
    checkOutput("hresp_err", {a, e}, {2'b01, 1'b1});
    checkOutput("hresp_lat", 2 + n - 1, 3);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Timeout: DATA spends exactly 16 wait edges, and the 16th ends it with err. rdata keeps the old value.
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h08, 32'h0, 32'h0);
    cyc(2);
    bus.hready_resp = 1'b0;
    waitAck(n, a, e, rd, ha);
    checkOutput("tmo_ack", {a, e}, {2'b10, 1'b1});
    checkOutput("tmo_lat", 2 + n - 1, 18);
    checkOutput("tmo_rdata", rd, 32'hABCD1234);
    applyStimulus(2'b01, 2'b00, 8'h04, 8'h00, 32'h0, 32'h0);
    cyc(3);
    checkOutput("tmo_idle_hold", {bus.hsel, bus.htrans, ack}, {1'b0, 2'b00, 2'b00});
    bus.hready_resp = 1'b1;
    waitAck(n, a, e, rd, ha);
    checkOutput("tmo_next_lat", n - 1, 3);
    checkOutput("tmo_next_ack", {a, e, rd}, {2'b01, 1'b0, 32'hABCD1234});
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // Reset during DATA aborts the transfer.
    applyStimulus(2'b01, 2'b01, 8'h0C, 8'h00, 32'hDEADBEEF, 32'h0);
    cyc(2);
    checkOutput("mid_hwdata", bus.hwdata, 32'hDEADBEEF);
    hresetn = 1'b0;
    cyc(1);
    checkOutput("mid_rst_bus", {bus.hsel, bus.hwrite, bus.htrans, bus.haddr}, {1'b0, 1'b0, 2'b00, 8'h00});
    checkOutput("mid_rst_hwdata", bus.hwdata, 32'h0);
    checkOutput("mid_rst_out", {ack, err, rdata}, {2'b00, 1'b0, 32'h0});
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    hresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checkOutput("mid_no_ack", ack, 2'b00);
    end
    applyStimulus(2'b11, 2'b00, 8'h04, 8'h08, 32'h0, 32'h0);
    waitAck(n, a, e, rd, ha);
    checkOutput("post_rst_tie", {a, rd}, {2'b01, 32'hABCD1234});
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    cyc(2);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sramc_ahb_arbiter.md
Name: sramc_ahb_arbiter

Overview:
- Two-requester AHB-lite master that shares one sramc_top slave port between requester 0 and requester 1.
- Each requester uses a simple req/ack interface. The block serialises requests with round-robin arbitration and sequences the AHB address and data phases. It also handles slave wait states, error responses and a hung-slave timeout.
- Sits between the on-chip clients and sramc_top; its AHB outputs connect directly to the sramc_top hsel/hwrite/htrans/hsize/haddr/hwdata pins.

Parameters:
- AW, 8: width of requester address and haddr.
- TIMEOUT_CYC, 16: wait-state cycles allowed in the data phase before abort; legal range 1..255.

Ports:
- hclk  in  1  clock; every register updates on its rising edge.
- hresetn  in  1  reset; synchronous and active-low.
- req  in  2  per-requester transfer request; held until ack.
- we  in  2  per-requester write enable (1 = write, 0 = read).
- addr0, addr1  in  AW  byte address; bits [1:0] ignored.
- wdata0, wdata1  in  32  write data.
- ack  out  2  one-cycle completion pulse per requester.
- err  out  1  valid with ack; 1 = hresp error or timeout.
- rdata  out  32  read data; valid with ack on a read.
- hsel  out  1  AHB slave select.
- hwrite  out  1  AHB write.
- htrans  out  2  AHB transfer type (2'b10 NONSEQ or 2'b00 IDLE).
- hsize  out  3  constant 3'b010 (word).
- haddr  out  AW  AHB address, bits [1:0] forced to 0.
- hwdata  out  32  AHB write data.
- hready_resp  in  1  slave ready.
- hresp  in  1  slave error response.
- hrdata  in  32  slave read data.

Behaviour:
- All outputs are registered.
- Reset state (hresetn=0 at a clock edge):
  - state=IDLE.
  - hsel=0, hwrite=0, htrans=2'b00, haddr=0, hwdata=0.
  - ack=0, err=0, rdata=0, wait counter=0.
  - last-grant pointer=1, so requester 0 wins the first tie.
- Reset mid-transfer aborts the transfer: no ack is issued, and the bus returns to IDLE on the next cycle.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - Arbitrate only when req≠0 and hready_resp=1. If hready_resp=0, stay in IDLE.
  - Winner: the sole requester if only one requests. If both request, the one not equal to last-grant; last-grant is then updated.
  - Latch winner id, we, address and wdata.
  - Drive hsel=1, htrans=2'b10, hwrite=we, haddr={addr[AW-1:2],2'b00}.
  - Next state: ADDR.
- ADDR:
  - Address phase is visible on the bus.
  - At the edge with hready_resp=1: drive hsel=0, htrans=2'b00, haddr=0, hwrite=0; hwdata=latched wdata for writes, 0 for reads. Next state: DATA.
  - If hready_resp=0: hold all outputs.
- DATA:
  - Edge with hready_resp=1: next state DONE. Capture hrdata into rdata if read. err=hresp.
  - Edge with hready_resp=0: increment wait counter. When the counter reaches TIMEOUT_CYC, go to DONE with err=1 and leave rdata unchanged.
- DONE:
  - ack[winner]=1 for exactly one cycle; clear hwdata and the wait counter; next state IDLE.
- Throughput: minimum 4 cycles per transfer, zero-wait latency from req sampled to ack high is 3 cycles. Each slave wait state adds 1 cycle.
- req dropped before ack: the transfer still completes and ack still pulses.
- A req still high in the cycle ack is high is not re-arbitrated until the next IDLE edge. Requesters must drop req in the ack cycle unless issuing a new transfer.
- No pipelining: only one transfer is in flight at any time.
- ack is never asserted on both bits at once; err=0 whenever ack=0.

Decomposition:
- Shared header sramc_ahb_defs.vh holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_WORD=3'b010.
  - FSM state encodings IDLE=0, ADDR=1, DATA=2, DONE=3.
- One sub-module, rr_arb2: combinational grant from req[1:0] plus a registered last-grant pointer, with a load enable driven by the IDLE→ADDR transition.

Test Plan:
- Write then read, zero wait: req0 write addr 0x04 data 0xABCD1234, then req0 read 0x04 → ack[0] 3 cycles after each req sample, rdata=0xABCD1234, err=0, hsize=3'b010 throughout.
- Simultaneous requests from reset: req=2'b11, r0 writes 0x00=0x11111111, r1 writes 0x08=0x22222222 → grants r0 then r1; both reads return the written values; a held 2'b11 then alternates r0,r1,r0.
- Address alignment: r1 read addr 0x07 → haddr=0x04 on the bus during ADDR.
- Wait states: slave model holds hready_resp=0 for 3 data-phase cycles → ack arrives 3 cycles later than zero-wait, hsel/haddr stable, correct rdata.
- Error and timeout:
  - hresp=1 at data-phase completion → ack with err=1.
  - hready_resp held low, TIMEOUT_CYC=16 → ack with err=1 exactly 16 wait cycles into DATA; rdata unchanged; the next request waits in IDLE until hready_resp=1.
- Reset mid-transfer: assert hresetn=0 during DATA → next cycle all outputs at reset values, no ack; the first post-reset tie grants r0.
